collision_scorer: RTL

Downstream consumer of the pipe stage's PipePosX/PipePosY.
- Compares the pipe against the bird's vertical position and the floor.
- Produces the registered Lost signal that freezes the pipe and bird stages.
- Keeps a 2-digit BCD score, counting pipes cleared, and a session high score for the display.
- Owns the game-level IDLE/PLAY/LOST sequencing and mirrors the pipe stage's Start handshake.

---
 rtl/collision_scorer_pkg.sv | 31 +++
 rtl/collision_scorer_if.sv | 21 ++
 rtl/collision_scorer_bcd_counter2.sv | 30 +++
 rtl/collision_scorer.sv | 116 +++++++++++
 4 files changed

// File: rtl/collision_scorer_pkg.sv
// Shared game geometry defaults, game-state encoding and BCD helper.
package collision_scorer_pkg;

    localparam int unsigned DEF_BIRD_X     = 200;
    localparam int unsigned DEF_BIRD_SIZE  = 20;
    localparam int unsigned DEF_PIPE_WIDTH = 60;
    localparam int unsigned DEF_GAP_HALF   = 60;
    localparam int unsigned DEF_FLOOR_Y    = 480;
    localparam int unsigned DEF_HIT_CYCLES = 2;

    // One-hot so every pipeline stage decodes the same state bits.
    typedef enum logic [2:0] {
        IDLE = 3'b001,
        PLAY = 3'b010,
        LOST = 3'b100
    } game_state_e;

    // Two-digit BCD increment that sticks at 99.
    function automatic logic [7:0] bcd_inc_sat(input logic [7:0] v);
        logic [7:0] r;
        if (v == 8'h99) begin
            r = v;
        end else if (v[3:0] == 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

endpackage

// File: rtl/collision_scorer_if.sv
// Pipe/bird positions in, game status and scores out.
interface collision_scorer_if;
    logic       Start;
    logic [9:0] BirdPosY;
    logic [9:0] PipePosX;
    logic [9:0] PipePosY;
    logic       Lost;
    logic [7:0] Score;
    logic [7:0] HighScore;
    logic       Playing;

    modport master (
        output Start, BirdPosY, PipePosX, PipePosY,
        input  Lost, Score, HighScore, Playing
    );

    modport slave (
        input  Start, BirdPosY, PipePosX, PipePosY,
        output Lost, Score, HighScore, Playing
    );
endinterface

// File: rtl/collision_scorer_bcd_counter2.sv
// Two-digit saturating BCD counter with synchronous clear and enable.
module collision_scorer_bcd_counter2
    import collision_scorer_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    output logic [7:0] count
);
    logic [7:0] count_d, count_q;

    // Clear dominates enable; increment saturates at 99.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = bcd_inc_sat(count_q);
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end

    assign count = count_q;
endmodule

// File: rtl/collision_scorer.sv
// Collision detection, hit debounce, scoring and IDLE/PLAY/LOST sequencing.
module collision_scorer
    import collision_scorer_pkg::*;
#(
    parameter int unsigned BIRD_X     = DEF_BIRD_X,
    parameter int unsigned BIRD_SIZE  = DEF_BIRD_SIZE,
    parameter int unsigned PIPE_WIDTH = DEF_PIPE_WIDTH,
    parameter int unsigned GAP_HALF   = DEF_GAP_HALF,
    parameter int unsigned FLOOR_Y    = DEF_FLOOR_Y,
    parameter int unsigned HIT_CYCLES = DEF_HIT_CYCLES
) (
    input  logic                Clk,
    input  logic                Reset,
    collision_scorer_if.slave   bus
);
    localparam int unsigned CW = $clog2(HIT_CYCLES + 1);
    localparam logic [CW-1:0] HIT_LAST = CW'(HIT_CYCLES - 1);
    localparam logic [CW-1:0] HIT_MAX  = CW'(HIT_CYCLES);

    game_state_e   state_d, state_q;
    logic [CW-1:0] hit_cnt_d, hit_cnt_q;
    logic [7:0]    high_d, high_q;
    logic          passed_d, passed_q;
    logic          lost_d, lost_q;
    logic          playing_d, playing_q;
    logic          score_clr, score_en;
    logic [7:0]    score;

    logic [10:0] by, px, py;
    logic        xov, yout, floor_hit, hit, pass, hit_go;

    // Geometry compares, all in 11 bits so sums cannot wrap.
    always_comb begin
        by = {1'b0, bus.BirdPosY};
        px = {1'b0, bus.PipePosX};
        py = {1'b0, bus.PipePosY};
        xov = (px < 11'(BIRD_X + BIRD_SIZE)) && (px + 11'(PIPE_WIDTH) > 11'(BIRD_X));
        // Gap top clamps at 0: expressed as by+GAP_HALF < py to avoid subtraction.
        yout = (by + 11'(GAP_HALF) < py) || (by + 11'(BIRD_SIZE) > py + 11'(GAP_HALF));
        floor_hit = (by + 11'(BIRD_SIZE) >= 11'(FLOOR_Y));
        hit = (xov && yout) || floor_hit;
        pass = (px + 11'(PIPE_WIDTH) < 11'(BIRD_X));
        hit_go = hit && (hit_cnt_q >= HIT_LAST);
    end

    // Next-state, debounce counter, score control and high-score update.
    always_comb begin
        state_d   = state_q;
        hit_cnt_d = hit_cnt_q;
        high_d    = high_q;
        score_clr = 1'b0;
        score_en  = 1'b0;
        passed_d  = pass;
        case (state_q)
            IDLE: begin
                hit_cnt_d = '0;
                if (bus.Start) begin
                    state_d   = PLAY;
                    score_clr = 1'b1;
                end
            end
            PLAY: begin
                if (hit) begin
                    hit_cnt_d = (hit_cnt_q == HIT_MAX) ? HIT_MAX : hit_cnt_q + CW'(1);
                end else begin
                    hit_cnt_d = '0;
                end
                if (hit_go) begin
                    state_d = LOST;
                    if (score > high_q) high_d = score;
                end else if (pass && !passed_q) begin
                    score_en = 1'b1;
                end
            end
            LOST: begin
                hit_cnt_d = '0;
                if (bus.Start) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        lost_d    = (state_d == LOST);
        playing_d = (state_d == PLAY);
    end

    // State and status registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= IDLE;
            hit_cnt_q <= '0;
            high_q    <= '0;
            passed_q  <= 1'b0;
            lost_q    <= 1'b0;
            playing_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hit_cnt_q <= hit_cnt_d;
            high_q    <= high_d;
            passed_q  <= passed_d;
            lost_q    <= lost_d;
            playing_q <= playing_d;
        end
    end

    collision_scorer_bcd_counter2 u_score (
        .clk   (Clk),
        .rst   (Reset),
        .clr   (score_clr),
        .en    (score_en),
        .count (score)
    );

    assign bus.Lost      = lost_q;
    assign bus.Playing   = playing_q;
    assign bus.Score     = score;
    assign bus.HighScore = high_q;
endmodule
